// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its BTB.
//   XLEN            : address width
//   BTB_IDX_W/TAG_W : index/tag widths for the default 16-entry BTB
//   btb_entry_t     : one BTB entry (valid, tag, target, 2-bit counter)
//   CTR_*           : 2-bit saturating counter encodings
package fetch_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned BTB_ENTRIES_DEF = 16;
    localparam int unsigned BTB_IDX_W       = $clog2(BTB_ENTRIES_DEF);
    localparam int unsigned BTB_TAG_W       = XLEN - BTB_IDX_W - 2;
    // Tag field is sized for the smallest legal table (4 entries) so one
    // struct serves every BTB_ENTRIES; unused upper tag bits stay zero.
    localparam int unsigned BTB_TAG_MAX_W   = XLEN - 2 - 2;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_STRONG_NT = 2'b00;
    localparam ctr_t CTR_WEAK_NT   = 2'b01;
    localparam ctr_t CTR_WEAK_T    = 2'b10;
    localparam ctr_t CTR_STRONG_T  = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [XLEN-1:0]          target;
        ctr_t                     ctr;
    } btb_entry_t;

    // Tag of a PC for a table with idx_w index bits, zero-extended.
    function automatic logic [BTB_TAG_MAX_W-1:0] btb_tag(
        input logic [XLEN-1:0] pc,
        input int unsigned     idx_w
    );
        return BTB_TAG_MAX_W'(pc >> (idx_w + 2));
    endfunction

    // Saturating 2-bit counter step.
    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != CTR_STRONG_T) r = c + 2'd1;
        end else begin
            if (c != CTR_STRONG_NT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk, rst                     : clock, async active-high reset
//   lookup_pc                    : PC to predict for
//   hit, taken, target           : lookup result (pre-update contents)
//   upd_valid/pc/target/taken    : resolved control-transfer update
module branch_target_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic            taken,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    btb_entry_t       lk_entry;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic             wr_en;
    btb_entry_t       wr_entry;

    // Lookup reads the registered table, so a same-cycle update is not visible.
    always_comb begin
        lk_idx   = lookup_pc[IDX_W+1:2];
        lk_entry = table_q[lk_idx];
        hit      = lk_entry.valid && (lk_entry.tag == btb_tag(lookup_pc, IDX_W));
        taken    = hit && lk_entry.ctr[1];
        target   = lk_entry.target;
    end

    // Update: train on hit, allocate only on a taken miss.
    always_comb begin
        upd_idx   = upd_pc[IDX_W+1:2];
        upd_entry = table_q[upd_idx];
        upd_hit   = upd_entry.valid && (upd_entry.tag == btb_tag(upd_pc, IDX_W));
        wr_en     = 1'b0;
        wr_entry  = upd_entry;
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_step(upd_entry.ctr, upd_taken);
                if (upd_taken) wr_entry.target = upd_target;
            end else if (upd_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = btb_tag(upd_pc, IDX_W);
                wr_entry.target = upd_target;
                wr_entry.ctr    = CTR_WEAK_T;
            end
        end
    end

    // Table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[upd_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC selection, BTB prediction,
// slot-invalid flag and performance counters.
//   clk, rst                       : clock, async active-high reset
//   pipeline_en                    : 1 = advance, 0 = hold PC
//   ex_redirect_valid/pc           : execute-stage correction
//   ex_update_*                    : BTB training from execute
//   imem_addr                      : next PC to synchronous-read imem
//   if_pc, if_predicted_pc         : PC on imem output and its prediction
//   if_pred_valid/taken, if_flush  : BTB hit, predicted taken, slot invalid
//   perf_fetch_count/redirect_count: saturating event counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
    parameter int unsigned  BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_update_valid,
    input  logic [31:0] ex_update_pc,
    input  logic [31:0] ex_update_target,
    input  logic        ex_update_taken,
    output logic [31:0] imem_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_predicted_pc,
    output logic        if_pred_valid,
    output logic        if_pred_taken,
    output logic        if_flush,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_redirect_count
);

    logic [XLEN-1:0] pc_q;
    logic            flush_q;
    logic [31:0]     fetch_cnt_q;
    logic [31:0]     redir_cnt_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            btb_hit;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            fetch_event;

    branch_target_buffer #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (pc_q),
        .hit        (btb_hit),
        .taken      (btb_taken),
        .target     (btb_target),
        .upd_valid  (ex_update_valid),
        .upd_pc     (ex_update_pc),
        .upd_target (ex_update_target),
        .upd_taken  (ex_update_taken)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC priority: reset, redirect, stall, predicted taken, sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (rst) begin
            next_pc = RESET_PC;
        end else if (ex_redirect_valid) begin
            next_pc = ex_redirect_pc;
        end else if (!pipeline_en) begin
            next_pc = pc_q;
        end else if (btb_taken) begin
            next_pc = btb_target;
        end
    end

    assign fetch_event = pipeline_en && !ex_redirect_valid && !flush_q;

    // PC, flush flag and counters; flush marks the slot after reset or redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            flush_q     <= 1'b1;
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            pc_q    <= next_pc;
            flush_q <= ex_redirect_valid;
            if (fetch_event && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ex_redirect_valid && (redir_cnt_q != 32'hFFFF_FFFF)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign imem_addr           = next_pc;
    assign if_pc               = pc_q;
    assign if_pred_valid       = btb_hit;
    assign if_pred_taken       = btb_taken;
    assign if_predicted_pc     = btb_taken ? btb_target : pc_plus4;
    assign if_flush            = flush_q;
    assign perf_fetch_count    = fetch_cnt_q;
    assign perf_redirect_count = redir_cnt_q;

endmodule
